// File: rtl/gen_fip_inner_prod_acc.sv
// gen_fip_inner_prod_acc
//   Signed fixed-point inner product over vectors longer than the datapath.
//   A job is i_beats_num beats of LANES element pairs. Each beat's products
//   are summed in a registered adder tree (stage 1). The tree sum is then
//   accumulated at full precision (stage 2). At the end the sum is aligned to
//   the result format, with truncate (floor) or round-half-up, and saturated
//   once.
//
// Ports
//   clk            rising-edge clock
//   sw_rst         synchronous active-high reset; discards any job in flight
//   i_start_pls    job start, sampled only while idle
//   i_beats_num    beats in the job (legal 1..MAX_BEATS), latched at start
//   i_rnd_mode     0 = truncate (floor), 1 = round half up, latched at start
//   i_valid        beat valid; accepted when o_ready is also high
//   i_vec1/i_vec2  packed two's-complement elements, lane k at [k*ONE_ELEM_W +: ONE_ELEM_W]
//   o_ready        high while beats are being accepted
//   o_busy         high whenever a job is in progress
//   o_valid_pls    one-cycle pulse when o_res/o_ovf carry a new result
//   o_res          signed saturated result, held until the next result
//   o_ovf          result was clipped by saturation
//   o_cfg_err_pls  one-cycle pulse for a start with an illegal beat count
module gen_fip_inner_prod_acc #(
  parameter int LANES            = 4,
  parameter int MAX_BEATS        = 4,
  parameter int ONE_ELEM_INT_W   = 1,
  parameter int ONE_ELEM_FRACT_W = 5,
  parameter int RES_INT_W        = 4,
  parameter int RES_FRACT_W      = 10,
  parameter int SIM_DLY          = 1,
  localparam int ONE_ELEM_W      = ONE_ELEM_INT_W + ONE_ELEM_FRACT_W,
  localparam int RES_W           = RES_INT_W + RES_FRACT_W,
  localparam int BN_W            = $clog2(MAX_BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        sw_rst,
  input  logic                        i_start_pls,
  input  logic [BN_W-1:0]             i_beats_num,
  input  logic                        i_rnd_mode,
  input  logic                        i_valid,
  input  logic [ONE_ELEM_W*LANES-1:0] i_vec1,
  input  logic [ONE_ELEM_W*LANES-1:0] i_vec2,
  output logic                        o_ready,
  output logic                        o_busy,
  output logic                        o_valid_pls,
  output logic [RES_W-1:0]            o_res,
  output logic                        o_ovf,
  output logic                        o_cfg_err_pls
);

  localparam int PROD_W = 2 * ONE_ELEM_W;
  localparam int LOG_L  = $clog2(LANES);
  localparam int SUM_W  = PROD_W + LOG_L;
  localparam int ACC_W  = 2 * ONE_ELEM_W + $clog2(LANES * MAX_BEATS) + 1;

  // Alignment from the product fraction width to the result fraction width.
  localparam int SH      = 2 * ONE_ELEM_FRACT_W - RES_FRACT_W;
  localparam int RSH     = (SH > 0) ? SH : 0;
  localparam int LSH     = (SH < 0) ? -SH : 0;
  localparam bit RND_EN  = (SH > 0);
  localparam int RND_POS = (SH > 0) ? SH - 1 : 0;
  // One spare bit for the rounding increment, plus room for a left shift,
  // and always at least one bit wider than the result so clipping is visible.
  localparam int ALIGN_W0 = ACC_W + 1 + LSH;
  localparam int ALIGN_W  = (ALIGN_W0 > RES_W) ? ALIGN_W0 : RES_W + 1;

  localparam logic signed [ALIGN_W-1:0] RES_MAX =
    {{(ALIGN_W - RES_W + 1){1'b0}}, {(RES_W - 1){1'b1}}};
  localparam logic signed [ALIGN_W-1:0] RES_MIN =
    {{(ALIGN_W - RES_W + 1){1'b1}}, {(RES_W - 1){1'b0}}};
  localparam logic [BN_W-1:0] MAX_BEATS_V = BN_W'(MAX_BEATS);

  // Elaboration-time parameter sanity checks.
  generate
    if ((LANES < 1) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
      $error("LANES must be a power of 2");
    end
    if (MAX_BEATS < 1) begin : g_bad_beats
      $error("MAX_BEATS must be at least 1");
    end
    if (SIM_DLY < 0) begin : g_bad_dly
      $error("SIM_DLY must be non-negative");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DRAIN, ST_DONE} state_t;

  state_t                   state_reg;
  logic [BN_W-1:0]          beats_left_reg;
  logic                     rnd_mode_reg;
  logic                     drain_cnt_reg;
  logic signed [SUM_W-1:0]  s1_sum_reg;
  logic                     s1_valid_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic                     ready_reg;
  logic                     busy_reg;
  logic                     valid_pls_reg;
  logic [RES_W-1:0]         res_reg;
  logic                     ovf_reg;
  logic                     cfg_err_reg;

  // ---------------------------------------------------------------- products
  logic signed [PROD_W-1:0] lane_prod [LANES];

  genvar gi, gj;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [ONE_ELEM_W-1:0] elem_a;
      logic signed [ONE_ELEM_W-1:0] elem_b;
      assign elem_a        = i_vec1[gi*ONE_ELEM_W +: ONE_ELEM_W];
      assign elem_b        = i_vec2[gi*ONE_ELEM_W +: ONE_ELEM_W];
      assign lane_prod[gi] = elem_a * elem_b;
    end
  endgenerate

  // --------------------------------------------- sign-extended adder tree
  // Level 0 holds the sign-extended products; each further level halves the
  // node count. Every node is SUM_W wide, so no level can overflow.
  generate
    for (gi = 0; gi <= LOG_L; gi++) begin : g_lvl
      localparam int NODES = LANES >> gi;
      logic signed [SUM_W-1:0] node [NODES];
      for (gj = 0; gj < NODES; gj++) begin : g_node
        if (gi == 0) begin : g_leaf
          assign node[gj] = SUM_W'(lane_prod[gj]);
        end else begin : g_add
          assign node[gj] = g_lvl[gi-1].node[2*gj] + g_lvl[gi-1].node[2*gj+1];
        end
      end
    end
  endgenerate

  logic signed [SUM_W-1:0] beat_sum;
  assign beat_sum = g_lvl[LOG_L].node[0];

  // -------------------------------------------------- align and saturate
  logic signed [ALIGN_W-1:0] acc_ext;
  logic signed [ALIGN_W-1:0] rnd_add;
  logic signed [ALIGN_W-1:0] aligned;
  logic [RES_W-1:0]          sat_res;
  logic                      sat_clip;

  always_comb begin
    acc_ext = ALIGN_W'(acc_reg);
    rnd_add = '0;
    if (RND_EN && rnd_mode_reg) begin
      rnd_add[RND_POS] = 1'b1;
    end
    // Arithmetic right shift gives floor; the half-LSB increment turns that
    // into round half up.
    aligned  = ((acc_ext + rnd_add) >>> RSH) <<< LSH;
    sat_res  = aligned[RES_W-1:0];
    sat_clip = 1'b0;
    if (aligned > RES_MAX) begin
      sat_res  = RES_MAX[RES_W-1:0];
      sat_clip = 1'b1;
    end else if (aligned < RES_MIN) begin
      sat_res  = RES_MIN[RES_W-1:0];
      sat_clip = 1'b1;
    end
  end

  // -------------------------------------------------------- control/datapath
  logic beat_accept;
  logic start_legal;
  assign beat_accept = (state_reg == ST_ACC) && i_valid;
  assign start_legal = (i_beats_num != '0) && (i_beats_num <= MAX_BEATS_V);

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_reg      <= ST_IDLE;
      beats_left_reg <= '0;
      rnd_mode_reg   <= 1'b0;
      drain_cnt_reg  <= 1'b0;
      s1_sum_reg     <= '0;
      s1_valid_reg   <= 1'b0;
      acc_reg        <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      valid_pls_reg  <= 1'b0;
      res_reg        <= '0;
      ovf_reg        <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      valid_pls_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;

      // Stage 1: register the beat's tree sum.
      s1_valid_reg <= beat_accept;
      if (beat_accept) begin
        s1_sum_reg <= beat_sum;
      end

      // Stage 2: accumulate. The clear on a legal start cannot collide with
      // a stage-1 beat because none is in flight while idle.
      if ((state_reg == ST_IDLE) && i_start_pls && start_legal) begin
        acc_reg <= '0;
      end else if (s1_valid_reg) begin
        acc_reg <= acc_reg + ACC_W'(s1_sum_reg);
      end

      case (state_reg)
        ST_IDLE: begin
          if (i_start_pls) begin
            if (start_legal) begin
              beats_left_reg <= i_beats_num;
              rnd_mode_reg   <= i_rnd_mode;
              ready_reg      <= 1'b1;
              busy_reg       <= 1'b1;
              state_reg      <= ST_ACC;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (i_valid) begin
            beats_left_reg <= beats_left_reg - 1'b1;
            if (beats_left_reg == BN_W'(1)) begin
              ready_reg     <= 1'b0;
              drain_cnt_reg <= 1'b0;
              state_reg     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Two cycles: one for stage 1 to land in the accumulator, one
          // spare so the result appears three edges after the last beat.
          if (drain_cnt_reg) begin
            state_reg <= ST_DONE;
          end else begin
            drain_cnt_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          res_reg       <= sat_res;
          ovf_reg       <= sat_clip;
          valid_pls_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_ready       = ready_reg;
  assign o_busy        = busy_reg;
  assign o_valid_pls   = valid_pls_reg;
  assign o_res         = res_reg;
  assign o_ovf         = ovf_reg;
  assign o_cfg_err_pls = cfg_err_reg;

endmodule

// File: tb/tb_gen_fip_inner_prod_acc.sv
// Testbench for gen_fip_inner_prod_acc. Two instances share all inputs:
// dut_a uses the default formats (no alignment shift), dut_b uses
// RES_FRACT_W = 8 (right shift by 2, so rounding matters).
module tb_gen_fip_inner_prod_acc;

  localparam int LANES = 4;
  localparam int MB    = 4;
  localparam int EW    = 6;
  localparam int RW_A  = 14;
  localparam int RW_B  = 12;

  logic clk = 1'b0;
  logic sw_rst;
  logic start;
  logic [2:0] beats;
  logic rnd;
  logic valid;
  logic [EW*LANES-1:0] vec1;
  logic [EW*LANES-1:0] vec2;

  logic ready_a, busy_a, vpls_a, ovf_a, cerr_a;
  logic [RW_A-1:0] res_a;
  logic ready_b, busy_b, vpls_b, ovf_b, cerr_b;
  logic [RW_B-1:0] res_b;

  int checks = 0;
  int failures = 0;

  int v1 [MB][LANES];
  int v2 [MB][LANES];

  always #5 clk = ~clk;

  gen_fip_inner_prod_acc dut_a (
    .clk(clk), .sw_rst(sw_rst), .i_start_pls(start), .i_beats_num(beats),
    .i_rnd_mode(rnd), .i_valid(valid), .i_vec1(vec1), .i_vec2(vec2),
    .o_ready(ready_a), .o_busy(busy_a), .o_valid_pls(vpls_a), .o_res(res_a),
    .o_ovf(ovf_a), .o_cfg_err_pls(cerr_a)
  );

  gen_fip_inner_prod_acc #(.RES_FRACT_W(8)) dut_b (
    .clk(clk), .sw_rst(sw_rst), .i_start_pls(start), .i_beats_num(beats),
    .i_rnd_mode(rnd), .i_valid(valid), .i_vec1(vec1), .i_vec2(vec2),
    .o_ready(ready_b), .o_busy(busy_b), .o_valid_pls(vpls_b), .o_res(res_b),
    .o_ovf(ovf_b), .o_cfg_err_pls(cerr_b)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer dot product, then scale by 2^-sh with floor or
  // round half up, then clip to the signed result range.
  function automatic longint model(input int nb, input bit rm, input int sh,
                                   input int resw, output bit ov);
    longint s, d, v, hi, lo;
    s = 0;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < LANES; k++)
        s += longint'(v1[b][k]) * longint'(v2[b][k]);
    if (sh > 0) begin
      d = longint'(1) << sh;
      if (rm) s += d / 2;
      v = s / d;
      if ((s % d) != 0 && s < 0) v--;
    end else begin
      v = s * (longint'(1) << (-sh));
    end
    hi = (longint'(1) << (resw - 1)) - 1;
    lo = -(longint'(1) << (resw - 1));
    ov = 1'b0;
    if (v > hi) begin v = hi; ov = 1'b1; end
    if (v < lo) begin v = lo; ov = 1'b1; end
    return v;
  endfunction

  task automatic clear_vecs();
    for (int b = 0; b < MB; b++)
      for (int k = 0; k < LANES; k++) begin
        v1[b][k] = 0;
        v2[b][k] = 0;
      end
  endtask

  task automatic fill_beat(input int b, input int x, input int y);
    for (int k = 0; k < LANES; k++) begin
      v1[b][k] = x;
      v2[b][k] = y;
    end
  endtask

  task automatic drive_beat(input int b);
    for (int k = 0; k < LANES; k++) begin
      vec1[k*EW +: EW] = EW'(v1[b][k]);
      vec2[k*EW +: EW] = EW'(v2[b][k]);
    end
  endtask

  // Runs one job and checks handshake, the E+3 result timing and both results.
  task automatic run_job(input string name, input int nb, input bit rm,
                         input int gap, input bit gap_rand, input bit hold_start);
    longint ea, eb;
    bit oa, ob;
    int g;
    ea = model(nb, rm, 0, RW_A, oa);
    eb = model(nb, rm, 2, RW_B, ob);
    start = 1'b1;
    beats = 3'(nb);
    rnd   = rm;
    tick();
    if (!hold_start) start = 1'b0;
    chk({name, "/busy_rise"}, busy_a, 1);
    for (int b = 0; b < nb; b++) begin
      g = gap_rand ? int'($urandom_range(gap, 0)) : gap;
      repeat (g) tick();
      chk({name, "/ready"}, ready_a, 1);
      drive_beat(b);
      valid = 1'b1;
      tick();
      valid = 1'b0;
    end
    start = 1'b0;
    chk({name, "/ready_fall"}, ready_a, 0);
    chk({name, "/busy_mid"}, busy_a, 1);
    tick();
    chk({name, "/no_pls_e1"}, vpls_a, 0);
    tick();
    chk({name, "/no_pls_e2"}, vpls_a, 0);
    tick();
    chk({name, "/pls_a"}, vpls_a, 1);
    chk({name, "/res_a"}, $signed(res_a), ea);
    chk({name, "/ovf_a"}, ovf_a, oa);
    chk({name, "/busy_fall"}, busy_a, 0);
    chk({name, "/pls_b"}, vpls_b, 1);
    chk({name, "/res_b"}, $signed(res_b), eb);
    chk({name, "/ovf_b"}, ovf_b, ob);
    tick();
    chk({name, "/pls_end"}, vpls_a, 0);
    $display("job %s beats=%0d rnd=%0d res_a=%0d ovf_a=%0d res_b=%0d ovf_b=%0d",
             name, nb, rm, $signed(res_a), ovf_a, $signed(res_b), ovf_b);
  endtask

  task automatic bad_start(input int nb);
    start = 1'b1;
    beats = 3'(nb);
    tick();
    start = 1'b0;
    chk("cfg_err_pls", cerr_a, 1);
    chk("cfg_err_busy", busy_a, 0);
    chk("cfg_err_ready", ready_a, 0);
    tick();
    chk("cfg_err_pls_end", cerr_a, 0);
    chk("cfg_err_busy2", busy_a, 0);
    $display("illegal start beats=%0d", nb);
  endtask

  initial begin
    sw_rst = 1'b1;
    start  = 1'b0;
    beats  = '0;
    rnd    = 1'b0;
    valid  = 1'b0;
    vec1   = '0;
    vec2   = '0;
    clear_vecs();
    repeat (3) tick();
    sw_rst = 1'b0;

    chk("rst_ready", ready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pls", vpls_a, 0);
    chk("rst_res", res_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_cfg_err", cerr_a, 0);
    tick();

    // Single beat: {2,2,10,0} x {-3,-3,21,0}
    clear_vecs();
    v1[0][3] = 2;  v1[0][2] = 2;  v1[0][1] = 10; v1[0][0] = 0;
    v2[0][3] = -3; v2[0][2] = -3; v2[0][1] = 21; v2[0][0] = 0;
    run_job("single", 1, 1'b0, 0, 1'b0, 1'b0);
    chk("single_const", $signed(res_a), 198);

    // Two beats with a 3-cycle valid gap
    clear_vecs();
    fill_beat(0, 31, 31);
    run_job("gap", 2, 1'b0, 3, 1'b0, 1'b0);
    chk("gap_const", $signed(res_a), 3844);

    // Saturation cases
    clear_vecs();
    for (int b = 0; b < 3; b++) fill_beat(b, 31, 31);
    run_job("sat_pos", 3, 1'b0, 0, 1'b0, 1'b0);
    chk("sat_pos_const", $signed(res_a), 8191);
    chk("sat_pos_ovf", ovf_a, 1);

    for (int b = 0; b < 3; b++) fill_beat(b, -32, 31);
    run_job("sat_neg", 3, 1'b0, 0, 1'b0, 1'b0);
    chk("sat_neg_const", $signed(res_a), -8192);

    clear_vecs();
    for (int b = 0; b < 2; b++) fill_beat(b, -32, -32);
    run_job("sat_edge", 2, 1'b0, 0, 1'b0, 1'b0);
    chk("sat_edge_const", $signed(res_a), 8191);
    chk("sat_edge_ovf", ovf_a, 1);

    // Rounding on the shifted instance
    clear_vecs();
    v1[0][0] = 1;  v2[0][0] = 3;
    run_job("rnd_p_tr", 1, 1'b0, 0, 1'b0, 1'b0);
    chk("rnd_p_tr_const", $signed(res_b), 0);
    run_job("rnd_p_rd", 1, 1'b1, 0, 1'b0, 1'b0);
    chk("rnd_p_rd_const", $signed(res_b), 1);
    v1[0][0] = -1;
    run_job("rnd_n_tr", 1, 1'b0, 0, 1'b0, 1'b0);
    chk("rnd_n_tr_const", $signed(res_b), -1);
    run_job("rnd_n_rd", 1, 1'b1, 0, 1'b0, 1'b0);
    chk("rnd_n_rd_const", $signed(res_b), -1);

    // Reset in the middle of a 3-beat job (last result is nonzero)
    clear_vecs();
    v1[0][0] = 31;  v2[0][0] = 31;
    run_job("pre_rst", 1, 1'b0, 0, 1'b0, 1'b0);
    fill_beat(0, 31, 31);
    start = 1'b1;
    beats = 3'd3;
    tick();
    start = 1'b0;
    drive_beat(0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("rst_mid_pls", vpls_a, 0);
      chk("rst_mid_busy", busy_a, 0);
      chk("rst_mid_ready", ready_a, 0);
      chk("rst_mid_res", res_a, 0);
      chk("rst_mid_ovf", ovf_a, 0);
      tick();
    end
    $display("mid-job reset applied");
    clear_vecs();
    v1[0][0] = 31;  v2[0][0] = 31;
    run_job("post_rst", 1, 1'b0, 0, 1'b0, 1'b0);
    chk("post_rst_const", $signed(res_a), 961);

    // Illegal beat counts
    bad_start(0);
    bad_start(5);
    bad_start(7);

    // Start held high during accumulation is ignored
    clear_vecs();
    for (int b = 0; b < 3; b++) fill_beat(b, 5 + b, -7 + 2 * b);
    run_job("hold_start", 3, 1'b1, 1, 1'b1, 1'b1);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int nb;
      nb = int'($urandom_range(MB, 1));
      clear_vecs();
      for (int b = 0; b < MB; b++)
        for (int k = 0; k < LANES; k++) begin
          v1[b][k] = int'($urandom_range(63)) - 32;
          v2[b][k] = int'($urandom_range(63)) - 32;
        end
      run_job($sformatf("rand%0d", j), nb, 1'($urandom_range(1)), 2, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
